// File: rtl/seq_check_ctrl.sv
// Job controller feeding a 2-bit seq_check detector from a byte stream.
// Flushes checker history, serialises bytes MSB-first, counts flag pulses.
module seq_check_ctrl #(
  parameter int CNT_W     = 8,
  parameter int DRAIN_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       len,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [1:0]       chk_data,
  input  logic             chk_flag,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt,
  output logic             sat,
  output logic             underrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_RUN, S_DRAIN, S_DONE
  } state_e;

  localparam logic [3:0]       DRAIN_LAST = 4'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = 1;

  state_e           state_q, state_d;
  logic [8:0]       len_q, len_d;
  logic [8:0]       acc_q, acc_d;
  logic [3:0]       cyc_q, cyc_d;
  logic [1:0]       pend_q, pend_d;
  logic [5:0]       sh_q, sh_d;
  logic [1:0]       chk_q, chk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             und_q, und_d;
  logic             more;
  logic             accept;
  logic             counting;

  assign more     = (acc_q != len_q);
  assign accept   = in_ready & in_valid;
  assign counting = (state_q == S_RUN) || (state_q == S_DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_FLUSH;
      S_FLUSH: if (cyc_q == 4'd3) state_d = S_RUN;
      S_RUN:   if (pend_q == 2'd0 && !more) state_d = S_DRAIN;
      S_DRAIN: if (cyc_q == DRAIN_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // pend_q == 0 means the current byte's last symbol is on chk_data or none is pending
  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    in_ready = ((state_q == S_FLUSH) && (cyc_q == 4'd3)) ||
               ((state_q == S_RUN) && more && (pend_q == 2'd0));
  end

  always_comb begin
    len_d  = len_q;
    acc_d  = acc_q;
    cyc_d  = cyc_q;
    pend_d = pend_q;
    sh_d   = sh_q;
    chk_d  = 2'b00;
    cnt_d  = cnt_q;
    sat_d  = sat_q;
    // an open ready window with no byte leaves the next slot empty
    und_d  = und_q | (in_ready & ~in_valid);
    if (state_q == S_IDLE && start) begin
      len_d  = {len == 8'd0, len};
      acc_d  = '0;
      cyc_d  = '0;
      pend_d = '0;
      cnt_d  = '0;
      sat_d  = 1'b0;
      und_d  = 1'b0;
    end
    if (state_q == S_FLUSH || state_q == S_DRAIN) begin
      cyc_d = (state_d == state_q) ? cyc_q + 4'd1 : 4'd0;
    end
    if (accept) begin
      chk_d  = in_data[7:6];
      sh_d   = in_data[5:0];
      pend_d = 2'd3;
      acc_d  = acc_q + 9'd1;
    end else if (state_q == S_RUN && pend_q != 2'd0) begin
      chk_d  = sh_q[5:4];
      sh_d   = {sh_q[3:0], 2'b00};
      pend_d = pend_q - 2'd1;
    end
    if (counting && chk_flag) begin
      if (&cnt_q) sat_d = 1'b1;
      else        cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q  <= '0;
      acc_q  <= '0;
      cyc_q  <= '0;
      pend_q <= '0;
      sh_q   <= '0;
      chk_q  <= '0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
      und_q  <= 1'b0;
    end else begin
      len_q  <= len_d;
      acc_q  <= acc_d;
      cyc_q  <= cyc_d;
      pend_q <= pend_d;
      sh_q   <= sh_d;
      chk_q  <= chk_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
      und_q  <= und_d;
    end
  end

  assign chk_data  = chk_q;
  assign match_cnt = cnt_q;
  assign sat       = sat_q;
  assign underrun  = und_q;

endmodule

// File: tb/tb_seq_check_ctrl.sv
// Bench for seq_check_ctrl: behavioural pattern checker on chk_data,
// expected results from a bit-stream scan of each job.
module tb_seq_check_ctrl;

  localparam logic [6:0] PAT = 7'b1011001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] len = 8'd0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       chk_flag = 1'b0;

  logic       in_ready, busy, done, sat, underrun;
  logic [1:0] chk_data;
  logic [7:0] match_cnt;
  logic       s_in_ready, s_busy, s_done, s_sat, s_und;
  logic [1:0] s_chk_data, s_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] jb[$];
  int         jg[$];

  seq_check_ctrl #(.CNT_W(8), .DRAIN_CYC(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .chk_data(chk_data), .chk_flag(chk_flag), .busy(busy),
    .done(done), .match_cnt(match_cnt), .sat(sat),
    .underrun(underrun)
  );

  seq_check_ctrl #(.CNT_W(2), .DRAIN_CYC(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(s_in_ready),
    .chk_data(s_chk_data), .chk_flag(chk_flag), .busy(s_busy),
    .done(s_done), .match_cnt(s_cnt), .sat(s_sat),
    .underrun(s_und)
  );

  always #5 clk = ~clk;

  // behavioural seq_check: flag one cycle after the symbol completing the pattern
  logic [5:0] hist = 6'd0;
  wire  [7:0] win = {hist, chk_data};
  always @(posedge clk) begin
    hist     <= win[5:0];
    chk_flag <= (win[7:1] == PAT) || (win[6:0] == PAT);
  end

  task automatic run_job(input string name, input bit rnd_start);
    int n, g_tot, last_sym, exp_done, hits, exp_cnt, exp_scnt;
    int bi, gleft, done_k;
    int sym_err, acc_err, rdy_err, flush_err;
    bit m;
    bit bits[$];
    logic [1:0] es[$];
    int acc_exp[$];
    int acc_got[$];
    logic [7:0] cnt_got;
    logic [1:0] scnt_got;
    logic sat_got, ssat_got, und_got;
    n = jb.size();
    g_tot = 0; hits = 0; done_k = -1;
    sym_err = 0; acc_err = 0; rdy_err = 0; flush_err = 0;
    cnt_got = 8'd0; scnt_got = 2'd0;
    sat_got = 1'b0; ssat_got = 1'b0; und_got = 1'b0;
    for (int i = 0; i < 8; i++) bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      g_tot += jg[i];
      acc_exp.push_back(4 + 4 * i + g_tot);
      for (int j = 0; j < jg[i]; j++) begin
        es.push_back(2'b00);
        bits.push_back(1'b0);
        bits.push_back(1'b0);
      end
      for (int b = 7; b >= 0; b--) bits.push_back(jb[i][b]);
      for (int s = 3; s >= 0; s--) es.push_back(jb[i][2*s +: 2]);
    end
    for (int i = 0; i + 7 <= bits.size(); i++) begin
      m = 1'b1;
      for (int j = 0; j < 7; j++) if (bits[i+j] != PAT[6-j]) m = 1'b0;
      if (m) hits++;
    end
    exp_cnt  = (hits > 255) ? 255 : hits;
    exp_scnt = (hits > 3) ? 3 : hits;
    last_sym = 4 + 4 * n + g_tot;
    exp_done = last_sym + 3;
    @(negedge clk);
    start = 1'b1;
    len = 8'(n);
    in_valid = 1'b0;
    bi = 0;
    gleft = jg[0];
    for (int k = 1; k <= exp_done + 20; k++) begin
      @(negedge clk);
      start = rnd_start ? ($urandom % 3 == 0) : 1'b0;
      if (k <= 4) begin
        if (chk_data !== 2'b00 || busy !== 1'b1 || in_ready !== (k == 4))
          flush_err++;
      end else if (k <= last_sym) begin
        if (chk_data !== es[k-5]) sym_err++;
      end else if (chk_data !== 2'b00) begin
        sym_err++;
      end
      if (done === 1'b1) begin
        done_k = k;
        cnt_got = match_cnt; scnt_got = s_cnt;
        sat_got = sat; ssat_got = s_sat; und_got = underrun;
      end
      if (in_ready === 1'b1) begin
        if (bi >= n) begin
          rdy_err++;
          in_valid = 1'b0;
        end else if (gleft > 0) begin
          in_valid = 1'b0;
          in_data = 8'($urandom);
          gleft--;
        end else begin
          in_valid = 1'b1;
          in_data = jb[bi];
          acc_got.push_back(k);
          bi++;
          if (bi < n) gleft = jg[bi];
        end
      end else begin
        in_valid = ($urandom % 2 == 0);
        in_data = 8'($urandom);
      end
      if (done_k >= 0) break;
    end
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    if (acc_got.size() != acc_exp.size()) acc_err++;
    else for (int i = 0; i < n; i++) if (acc_got[i] != acc_exp[i]) acc_err++;
    n_tests++;
    if (flush_err != 0) begin
      n_fail++;
      $display("FAIL %s flush: %0d bad cycles, want 0", name, flush_err);
    end
    n_tests++;
    if (sym_err != 0) begin
      n_fail++;
      $display("FAIL %s chk_data: %0d bad symbols, want 0", name, sym_err);
    end
    n_tests++;
    if (acc_err != 0) begin
      n_fail++;
      $display("FAIL %s accept_times: %0d wrong (got %0d bytes, want %0d)",
               name, acc_err, acc_got.size(), n);
    end
    n_tests++;
    if (rdy_err != 0) begin
      n_fail++;
      $display("FAIL %s extra_ready: %0d cycles, want 0", name, rdy_err);
    end
    n_tests++;
    if (done_k != exp_done) begin
      n_fail++;
      $display("FAIL %s done_cycle: got %0d want %0d", name, done_k, exp_done);
    end
    n_tests++;
    if (cnt_got !== 8'(exp_cnt)) begin
      n_fail++;
      $display("FAIL %s match_cnt: got %0d want %0d", name, cnt_got, exp_cnt);
    end
    n_tests++;
    if (sat_got !== (hits > 255)) begin
      n_fail++;
      $display("FAIL %s sat: got %b want %b", name, sat_got, hits > 255);
    end
    n_tests++;
    if (und_got !== (g_tot > 0)) begin
      n_fail++;
      $display("FAIL %s underrun: got %b want %b", name, und_got, g_tot > 0);
    end
    n_tests++;
    if (scnt_got !== 2'(exp_scnt)) begin
      n_fail++;
      $display("FAIL %s cnt2_match: got %0d want %0d", name, scnt_got, exp_scnt);
    end
    n_tests++;
    if (ssat_got !== (hits > 3)) begin
      n_fail++;
      $display("FAIL %s cnt2_sat: got %b want %b", name, ssat_got, hits > 3);
    end
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || match_cnt !== cnt_got) begin
      n_fail++;
      $display("FAIL %s after_done: busy=%b done=%b cnt=%0d want 0 0 %0d",
               name, busy, done, match_cnt, cnt_got);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_tests++;
    if ({busy, done, in_ready, chk_data, match_cnt, sat, underrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b rdy=%b chk=%b cnt=%0d sat=%b und=%b want all 0",
               busy, done, in_ready, chk_data, match_cnt, sat, underrun);
    end
    n_tests++;
    if ({s_busy, s_done, s_in_ready, s_chk_data, s_cnt, s_sat, s_und} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_cnt2: got nonzero, want all 0");
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || chk_data !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b chk=%b want 0 00", busy, chk_data);
    end
  endtask

  task automatic test_single_hit();
    jb = '{8'hB3}; jg = '{0};
    run_job("single_hit", 1'b0);
  endtask

  task automatic test_two_bytes();
    jb = '{8'hB3, 8'hB2}; jg = '{0, 0};
    run_job("two_bytes", 1'b0);
  endtask

  task automatic test_no_hit();
    jb = '{8'h00, 8'h00, 8'h00, 8'h00}; jg = '{0, 0, 0, 0};
    run_job("no_hit", 1'b0);
  endtask

  task automatic test_underrun();
    jb = '{8'hB3, 8'hB2}; jg = '{0, 3};
    run_job("underrun", 1'b1);
  endtask

  task automatic test_saturation();
    jb = '{8'hB3, 8'hB3, 8'hB3, 8'hB3}; jg = '{0, 0, 0, 0};
    run_job("saturation", 1'b0);
  endtask

  task automatic test_reset_mid_job();
    int seen;
    logic was_busy;
    @(negedge clk);
    start = 1'b1;
    len = 8'd3;
    repeat (9) begin
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1;
      in_data = 8'hB3;
    end
    was_busy = busy;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (was_busy !== 1'b1 ||
        {busy, done, in_ready, chk_data, match_cnt, sat, underrun} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: was_busy=%b busy=%b chk=%b cnt=%0d want 1 0 00 0",
               was_busy, busy, chk_data, match_cnt);
    end
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL mid_reset_quiet: %0d active cycles, want 0", seen);
    end
    jb = '{8'hB3}; jg = '{0};
    run_job("after_reset", 1'b0);
  endtask

  task automatic test_full_len();
    jb.delete(); jg.delete();
    for (int i = 0; i < 256; i++) begin
      jb.push_back(8'($urandom));
      jg.push_back(0);
    end
    run_job("len_256", 1'b0);
  endtask

  task automatic test_random();
    int n, r;
    for (int t = 0; t < 25; t++) begin
      jb.delete(); jg.delete();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        r = $urandom % 4;
        jb.push_back(r == 0 ? 8'hB3 : r == 1 ? 8'hB2 : 8'($urandom));
        jg.push_back(($urandom % 5 == 0) ? $urandom_range(1, 3) : 0);
      end
      run_job($sformatf("random%0d", t), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_two_bytes();
    test_no_hit();
    test_underrun();
    test_saturation();
    test_reset_mid_job();
    test_full_len();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
